// File: rtl/mdu_sched.sv
// rtl/mdu_sched.sv - multiply/divide scheduler owning the HI/LO registers
//
// Purpose: accepts mult/multu/div/divu/mthi/mtlo from the E stage, latches the
// operands, holds a fixed-latency busy window and writes HI/LO at its end.
// It also raises the HI/LO hazard stall request for the D stage.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-low
//   start      valid command in E this cycle
//   op         0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
//   rs_val     dividend / multiplicand / mthi-mtlo data
//   rt_val     divisor / multiplier
//   md_use_d   D-stage instruction touches the MDU
//   busy       operation in flight
//   stall_req  combinational stall request to the hazard unit
//   hi, lo     HI and LO registers
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic             issue, done, wr_en;

  logic             sgn, a_neg, b_neg;
  logic [63:0]      ext_a, ext_b, prod;
  logic [31:0]      a_mag, b_mag, divisor, quo, rem;
  logic [31:0]      res_hi, res_lo;

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // next state; issue starts a mult/div, done marks the final busy edge
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !op[2]) begin
          issue   = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(1)) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state == RUN);
  assign stall_req = md_use_d & (busy | (start & ~op[2]));

  // Arithmetic from latched operands only. Signed ops use magnitudes so the
  // 0x80000000 / -1 corner falls out naturally without signed overflow.
  always_comb begin
    sgn     = ~op_q[0];
    a_neg   = sgn & a_q[31];
    b_neg   = sgn & b_q[31];
    ext_a   = {{32{a_neg}}, a_q};
    ext_b   = {{32{b_neg}}, b_q};
    // low 64 bits of the product of sign-extended operands equal the signed product
    prod    = ext_a * ext_b;
    a_mag   = a_neg ? (32'd0 - a_q) : a_q;
    b_mag   = b_neg ? (32'd0 - b_q) : b_q;
    // divide-by-zero never writes back; the guard only keeps the divider defined
    divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    quo     = a_mag / divisor;
    rem     = a_mag % divisor;
    res_hi  = prod[63:32];
    res_lo  = prod[31:0];
    if (op_q[1]) begin
      res_lo = (a_neg ^ b_neg) ? (32'd0 - quo) : quo;
      res_hi = a_neg ? (32'd0 - rem) : rem;
    end
  end

  assign wr_en = done & ~(op_q[1] & (b_q == 32'd0));

  // datapath: operand latch, down-counter, HI/LO
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      op_q <= 2'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      hi   <= 32'd0;
      lo   <= 32'd0;
    end else begin
      if (issue) begin
        op_q <= op[1:0];
        a_q  <= rs_val;
        b_q  <= rt_val;
        cnt  <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (state == RUN) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (wr_en) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == IDLE && start && op == 3'd4) begin
        hi <= rs_val;
      end else if (state == IDLE && start && op == 3'd5) begin
        lo <= rs_val;
      end
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// tb/tb_mdu_sched.sv - directed self-checking bench for mdu_sched
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_d;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_assert = 0;
  int n_fail   = 0;
  int n_busy;

  mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .md_use_d  (md_use_d),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // drive a command for one edge; stall_req is checked in the issue cycle
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic exp_stall);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    #1;
    chk("stall_issue", {31'd0, stall_req}, {31'd0, exp_stall});
    tick();
    start = 1'b0;
  endtask

  // count busy cycles (bounded), checking stall_req in each of them
  task automatic wait_idle(input logic exp_stall, output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      chk("stall_busy", {31'd0, stall_req}, {31'd0, exp_stall});
      n++;
      tick();
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    op       = 3'd7;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    md_use_d = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    tick();

    // mult -2 * 3 with md_use_d held high
    md_use_d = 1'b1;
    issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
    wait_idle(1'b1, n_busy);
    chk("mult_cycles", n_busy, 32'd5);
    chk("mult_stall_after", {31'd0, stall_req}, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    md_use_d = 1'b0;

    // multu 0xFFFFFFFF * 2, issued the first idle cycle, no stall without md_use_d
    issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle(1'b0, n_busy);
    chk("multu_cycles", n_busy, 32'd5);
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // divu 7 / 2
    issue(3'd3, 32'd7, 32'd2, 1'b0);
    wait_idle(1'b0, n_busy);
    chk("divu_cycles", n_busy, 32'd10);
    chk("divu_hi", hi, 32'd1);
    chk("divu_lo", lo, 32'd3);

    // div -7 / 2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(1'b0, n_busy);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);

    // div 0x80000000 / -1
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(1'b0, n_busy);
    chk("div_ovf_hi", hi, 32'd0);
    chk("div_ovf_lo", lo, 32'h8000_0000);

    // div 5 / 0: full window, HI/LO untouched
    issue(3'd2, 32'd5, 32'd0, 1'b0);
    wait_idle(1'b0, n_busy);
    chk("div0_cycles", n_busy, 32'd10);
    chk("div0_hi", hi, 32'd0);
    chk("div0_lo", lo, 32'h8000_0000);

    // mthi then mtlo on consecutive cycles
    start  = 1'b1;
    op     = 3'd4;
    rs_val = 32'h1234_5678;
    tick();
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'h8000_0000);
    op     = 3'd5;
    rs_val = 32'h9ABC_DEF0;
    tick();
    start = 1'b0;
    chk("mtlo_hi", hi, 32'h1234_5678);
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);

    // no-op command leaves everything alone
    issue(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_hi", hi, 32'h1234_5678);
    chk("nop_lo", lo, 32'h9ABC_DEF0);

    // mult 3 * 4 with mthi held on start throughout RUN
    issue(3'd0, 32'd3, 32'd4, 1'b0);
    start  = 1'b1;
    op     = 3'd4;
    rs_val = 32'hDEAD_BEEF;
    wait_idle(1'b0, n_busy);
    start = 1'b0;
    chk("m34_cycles", n_busy, 32'd5);
    chk("m34_hi", hi, 32'd0);
    chk("m34_lo", lo, 32'd12);
    tick();
    chk("m34_hold_hi", hi, 32'd0);

    // reset during busy cycle 4 of div 100 / 3
    issue(3'd2, 32'd100, 32'd3, 1'b0);
    tick();
    tick();
    tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);

    // restart div 100 / 3, operands change during RUN
    issue(3'd2, 32'd100, 32'd3, 1'b0);
    rs_val = 32'd7;
    rt_val = 32'd0;
    wait_idle(1'b0, n_busy);
    chk("hold_cycles", n_busy, 32'd10);
    chk("hold_hi", hi, 32'd1);
    chk("hold_lo", lo, 32'd33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_sched.md
# mdu_sched

Multiply/divide scheduler for the pipelined MIPS core. It sits in the E stage and owns the HI/LO registers. It accepts mult/multu/div/divu/mthi/mtlo commands, latches the operands, and holds a busy window of fixed latency. It also raises the stall request that the hazard unit uses to freeze D-stage instructions that touch HI/LO while an operation is in flight.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-low: reset==0 at a rising clk edge resets the block
- start  in  1  valid command in E stage this cycle
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo data)
- rt_val  in  32  forwarded rt operand (divisor / multiplier)
- md_use_d  in  1  D-stage instruction is an MDU instruction (mult/div/mf/mt)
- busy  out  1  operation in flight
- stall_req  out  1  combinational: md_use_d & (busy | (start & op<=3))
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- State machine has two states.
  - IDLE: busy=0.
  - RUN: busy=1, with a down-counter cnt (4 bits minimum, sized for max(MULT_CYCLES, DIV_CYCLES)).
- IDLE, start, op∈{0..3}:
  - Latch rs_val, rt_val and op.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- IDLE, start, op=4 / op=5:
  - hi←rs_val / lo←rs_val at that edge.
  - Stay IDLE.
- IDLE, start, op∈{6,7}: nothing happens.
- RUN: cnt decrements each edge.
  - On the edge where cnt==1, write HI/LO from the latched operands and go to IDLE.
- start is ignored while in RUN, including mthi/mtlo. The hazard unit guarantees no such issue, so the bench checks it only as a don't-care that must not corrupt HI/LO.
- Arithmetic:
  - mult: {hi,lo} = signed 32×32 → 64.
  - multu: {hi,lo} = unsigned 32×32 → 64.
  - div: lo = signed quotient, truncated toward zero. hi = remainder, with the sign of the dividend.
  - divu: lo = unsigned quotient, hi = unsigned remainder.
- Boundary cases:
  - Divisor 0 (div or divu): full DIV_CYCLES busy window, then HI/LO unchanged.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Results are computed from the latched operands only. Input changes during RUN have no effect.

## Timing
- Reset (reset==0 at an edge):
  - busy=0, hi=0, lo=0, state IDLE.
  - Any in-flight operation is aborted with no HI/LO write.
- Command sampled at edge T:
  - busy=1 from after T through the cycle before edge T+N (N = MULT_CYCLES or DIV_CYCLES).
  - HI/LO are updated at edge T+N and busy drops at the same edge.
  - A new command may be sampled at edge T+N+1 at the earliest, i.e. the first cycle busy=0.
- mthi/mtlo have 1-cycle latency: the value is visible on hi/lo after edge T.
- stall_req is asserted in the issue cycle itself (start & op<=3) so that an mfhi in D directly behind a mult stalls with zero bubble error.
- hi/lo are registered outputs with no combinational path from the inputs. Only stall_req is combinational.

## Test plan
- **Reset then mult:**
  - Stimulus: reset low 2 cycles, then mult rs=0xFFFFFFFE (−2), rt=3.
  - Required response: busy exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Checks before start: hi=lo=0.
- **multu and divu:**
  - multu 0xFFFFFFFF×2: hi=1, lo=0xFFFFFFFE after 5 cycles.
  - divu 7/2: lo=3, hi=1 after 10 cycles.
- **Signed division corners:**
  - div −7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div 0x80000000/−1: lo=0x80000000, hi=0.
  - div 5/0: busy 10 cycles, HI/LO keep their previous values.
- **Stall generation:**
  - Issue mult with md_use_d=1 held: stall_req=1 in the issue cycle and all 5 busy cycles, 0 after.
  - With md_use_d=0: stall_req=0 throughout.
- **Reset mid-operation and input hold:**
  - Start div 100/3; drive reset low at busy cycle 4: busy→0, hi=lo=0, no later write.
  - Restart div 100/3 and change rs/rt during RUN: result still lo=33, hi=1.
- **mthi/mtlo and back-to-back:**
  - mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles: hi/lo updated one edge after each.
  - Then mult 3×4 issued the cycle busy falls after a prior op: accepted, lo=12, hi=0.
  - start asserted during RUN: ignored, HI/LO uncorrupted.
